// File: rtl/big_state_machine_if.sv
// FlippyBit controller bus: lane flags in, score/state/respawn out.
// Clock and reset stay plain ports on the controller.
interface big_state_machine_if;
    logic [2:0] game_over;
    logic [2:0] correct;
    logic [2:0] reset_signal;
    logic [7:0] score;
    logic [2:0] state;

    modport master (
        output game_over,
        output correct,
        input  reset_signal,
        input  score,
        input  state
    );

    modport slave (
        input  game_over,
        input  correct,
        output reset_signal,
        output score,
        output state
    );
endinterface

// File: rtl/big_state_machine.sv
// FlippyBit three-lane game controller.
// Scores rising correct flags, saturating at 255; any lane loss ends the game.
module big_state_machine (
    input  logic                clock,
    input  logic                reset_button,
    big_state_machine_if.slave  bus
);
    typedef enum logic [2:0] {
        INIT      = 3'd0,
        PLAY      = 3'd1,
        GAME_OVER = 3'd2
    } state_t;

    state_t     state_q;
    state_t     state_d;
    logic [7:0] score_q;
    logic [7:0] score_d;
    logic [2:0] rst_q;
    logic [2:0] rst_d;
    logic [2:0] correct_prev;

    logic [2:0] rise;
    logic [1:0] n_rise;
    logic [8:0] sum;
    logic [7:0] score_sat;

    // Per-lane rising edges and the saturated score they would produce.
    always_comb begin
        rise      = bus.correct & ~correct_prev;
        n_rise    = {1'b0, rise[0]} + {1'b0, rise[1]} + {1'b0, rise[2]};
        sum       = {1'b0, score_q} + {7'b0, n_rise};
        score_sat = sum[8] ? 8'hFF : sum[7:0];
    end

    // Next-state, score and respawn request selection.
    always_comb begin
        state_d = state_q;
        score_d = score_q;
        rst_d   = rst_q;
        case (state_q)
            INIT: begin
                state_d = PLAY;
                rst_d   = 3'b000;
            end
            PLAY: begin
                if (|bus.game_over) begin
                    state_d = GAME_OVER;
                    rst_d   = 3'b111;
                end else begin
                    score_d = score_sat;
                    rst_d   = rise;
                end
            end
            GAME_OVER: begin
                rst_d = 3'b111;
            end
            default: begin
                state_d = INIT;
                rst_d   = 3'b111;
            end
        endcase
    end

    // State registers with synchronous restart taking priority.
    always_ff @(posedge clock) begin
        if (reset_button) begin
            state_q      <= INIT;
            score_q      <= 8'd0;
            rst_q        <= 3'b111;
            correct_prev <= 3'b000;
        end else begin
            state_q      <= state_d;
            score_q      <= score_d;
            rst_q        <= rst_d;
            correct_prev <= bus.correct;
        end
    end

    assign bus.state        = state_q;
    assign bus.score        = score_q;
    assign bus.reset_signal = rst_q;
endmodule

// File: tb/tb_big_state_machine.sv
// Self-checking bench for big_state_machine against a game-rules model.
// Directed scenarios followed by a randomized play session.
module tb_big_state_machine;
    logic clock;
    logic reset_button;

    big_state_machine_if ifc ();

    big_state_machine dut (
        .clock        (clock),
        .reset_button (reset_button),
        .bus          (ifc.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_vec;
    int n_err;

    // Game-rules model: 0 = init, 1 = play, 2 = over.
    int         m_phase;
    int         m_score;
    logic [2:0] m_resp;
    logic [2:0] m_last;
    logic [2:0] exp_st;
    logic [7:0] exp_sc;

    task automatic tick();
        logic [2:0] newly;
        @(posedge clock);
        if (reset_button) begin
            m_phase = 0;
            m_score = 0;
            m_resp  = 3'b111;
            m_last  = 3'b000;
        end else begin
            newly  = ifc.correct & ~m_last;
            m_last = ifc.correct;
            if (m_phase == 0) begin
                m_phase = 1;
                m_resp  = 3'b000;
            end else if (m_phase == 1) begin
                if (ifc.game_over != 3'b000) begin
                    m_phase = 2;
                    m_resp  = 3'b111;
                end else begin
                    m_score = m_score + $countones(newly);
                    if (m_score > 255) m_score = 255;
                    m_resp = newly;
                end
            end else begin
                m_resp = 3'b111;
            end
        end
        exp_st = 3'(m_phase);
        exp_sc = 8'(m_score);
        #1;
    endtask

    task automatic drive(input logic rb, input logic [2:0] go,
                         input logic [2:0] cor);
        reset_button  = rb;
        ifc.game_over = go;
        ifc.correct   = cor;
    endtask

    task automatic test_reset();
        drive(1'b1, 3'b000, 3'b000);
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++;
            if ({ifc.state, ifc.score, ifc.reset_signal} !==
                {3'd0, 8'd0, 3'b111}) begin
                n_err++;
                $display("FAIL reset_hold: got st=%0d sc=%0d rs=%b want st=0 sc=0 rs=111",
                         ifc.state, ifc.score, ifc.reset_signal);
            end
        end
        drive(1'b0, 3'b000, 3'b000);
        tick();
        n_vec++;
        if ({ifc.state, ifc.score, ifc.reset_signal} !==
            {3'd1, 8'd0, 3'b000}) begin
            n_err++;
            $display("FAIL reset_release: got st=%0d sc=%0d rs=%b want st=1 sc=0 rs=000",
                     ifc.state, ifc.score, ifc.reset_signal);
        end
    endtask

    task automatic test_single_correct();
        logic [2:0] lanes [3];
        lanes[0] = 3'b010;
        lanes[1] = 3'b001;
        lanes[2] = 3'b100;
        for (int l = 0; l < 3; l++) begin
            for (int c = 0; c < 6; c++) begin
                drive(1'b0, 3'b000, (c < 5) ? lanes[l] : 3'b000);
                tick();
                n_vec++;
                if ({ifc.state, ifc.score, ifc.reset_signal} !==
                    {exp_st, exp_sc, m_resp}) begin
                    n_err++;
                    $display("FAIL single_correct: got st=%0d sc=%0d rs=%b want st=%0d sc=%0d rs=%b",
                             ifc.state, ifc.score, ifc.reset_signal,
                             exp_st, exp_sc, m_resp);
                end
            end
        end
        n_vec++;
        if (ifc.score !== 8'd3) begin
            n_err++;
            $display("FAIL single_total: got sc=%0d want sc=3", ifc.score);
        end
    endtask

    task automatic test_simultaneous();
        drive(1'b0, 3'b000, 3'b111);
        tick();
        n_vec++;
        if ({ifc.score, ifc.reset_signal} !== {8'd6, 3'b111}) begin
            n_err++;
            $display("FAIL simultaneous: got sc=%0d rs=%b want sc=6 rs=111",
                     ifc.score, ifc.reset_signal);
        end
        tick();
        n_vec++;
        if ({ifc.score, ifc.reset_signal} !== {8'd6, 3'b000}) begin
            n_err++;
            $display("FAIL simul_hold: got sc=%0d rs=%b want sc=6 rs=000",
                     ifc.score, ifc.reset_signal);
        end
        drive(1'b0, 3'b000, 3'b000);
        tick();
    endtask

    task automatic test_saturation();
        logic [2:0] pat;
        drive(1'b1, 3'b000, 3'b000);
        tick();
        drive(1'b0, 3'b000, 3'b000);
        tick();
        for (int p = 0; p < 87; p++) begin
            pat = (p < 84) ? 3'b111 : (p == 84) ? 3'b011 : 3'b111;
            for (int h = 0; h < 2; h++) begin
                drive(1'b0, 3'b000, (h == 0) ? pat : 3'b000);
                tick();
                n_vec++;
                if ({ifc.state, ifc.score, ifc.reset_signal} !==
                    {exp_st, exp_sc, m_resp}) begin
                    n_err++;
                    $display("FAIL saturation: got st=%0d sc=%0d rs=%b want st=%0d sc=%0d rs=%b",
                             ifc.state, ifc.score, ifc.reset_signal,
                             exp_st, exp_sc, m_resp);
                end
            end
            if (p == 84) begin
                n_vec++;
                if (ifc.score !== 8'd254) begin
                    n_err++;
                    $display("FAIL preload_254: got sc=%0d want sc=254", ifc.score);
                end
            end
        end
        n_vec++;
        if (ifc.score !== 8'd255) begin
            n_err++;
            $display("FAIL saturate_255: got sc=%0d want sc=255", ifc.score);
        end
    endtask

    task automatic test_game_over();
        drive(1'b1, 3'b000, 3'b000);
        tick();
        drive(1'b0, 3'b000, 3'b000);
        tick();
        for (int p = 0; p < 5; p++) begin
            drive(1'b0, 3'b000, 3'b001);
            tick();
            drive(1'b0, 3'b000, 3'b000);
            tick();
        end
        drive(1'b0, 3'b100, 3'b000);
        tick();
        n_vec++;
        if ({ifc.state, ifc.score, ifc.reset_signal} !==
            {3'd2, 8'd5, 3'b111}) begin
            n_err++;
            $display("FAIL game_over: got st=%0d sc=%0d rs=%b want st=2 sc=5 rs=111",
                     ifc.state, ifc.score, ifc.reset_signal);
        end
        for (int i = 0; i < 12; i++) begin
            drive(1'b0, 3'($urandom), 3'($urandom));
            tick();
            n_vec++;
            if ({ifc.state, ifc.score, ifc.reset_signal} !==
                {3'd2, 8'd5, 3'b111}) begin
                n_err++;
                $display("FAIL over_hold: got st=%0d sc=%0d rs=%b want st=2 sc=5 rs=111",
                         ifc.state, ifc.score, ifc.reset_signal);
            end
        end
    endtask

    task automatic test_priority();
        drive(1'b1, 3'b000, 3'b000);
        tick();
        drive(1'b0, 3'b000, 3'b000);
        tick();
        tick();
        drive(1'b0, 3'b001, 3'b010);
        tick();
        n_vec++;
        if ({ifc.state, ifc.score, ifc.reset_signal} !==
            {3'd2, 8'd0, 3'b111}) begin
            n_err++;
            $display("FAIL priority: got st=%0d sc=%0d rs=%b want st=2 sc=0 rs=111",
                     ifc.state, ifc.score, ifc.reset_signal);
        end
    endtask

    task automatic test_mid_game_reset();
        drive(1'b1, 3'b000, 3'b000);
        tick();
        drive(1'b0, 3'b000, 3'b000);
        tick();
        for (int p = 0; p < 7; p++) begin
            drive(1'b0, 3'b000, 3'b100);
            tick();
            drive(1'b0, 3'b000, 3'b000);
            tick();
        end
        n_vec++;
        if (ifc.score !== 8'd7) begin
            n_err++;
            $display("FAIL preload_7: got sc=%0d want sc=7", ifc.score);
        end
        drive(1'b1, 3'b000, 3'b000);
        tick();
        n_vec++;
        if ({ifc.state, ifc.score, ifc.reset_signal} !==
            {3'd0, 8'd0, 3'b111}) begin
            n_err++;
            $display("FAIL mid_reset: got st=%0d sc=%0d rs=%b want st=0 sc=0 rs=111",
                     ifc.state, ifc.score, ifc.reset_signal);
        end
        drive(1'b0, 3'b000, 3'b000);
        tick();
        n_vec++;
        if (ifc.state !== 3'd1) begin
            n_err++;
            $display("FAIL mid_restart: got st=%0d want st=1", ifc.state);
        end
    endtask

    task automatic test_random();
        logic       rb;
        logic [2:0] go;
        for (int i = 0; i < 3000; i++) begin
            rb = ($urandom_range(0, 59) == 0);
            go = ($urandom_range(0, 39) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
            drive(rb, go, 3'($urandom));
            tick();
            n_vec++;
            if ({ifc.state, ifc.score, ifc.reset_signal} !==
                {exp_st, exp_sc, m_resp}) begin
                n_err++;
                $display("FAIL random[%0d]: got st=%0d sc=%0d rs=%b want st=%0d sc=%0d rs=%b",
                         i, ifc.state, ifc.score, ifc.reset_signal,
                         exp_st, exp_sc, m_resp);
            end
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        m_phase = 0;
        m_score = 0;
        m_resp  = 3'b111;
        m_last  = 3'b000;
        exp_st  = 3'd0;
        exp_sc  = 8'd0;
        drive(1'b1, 3'b000, 3'b000);
        test_reset();
        test_single_correct();
        test_simultaneous();
        test_saturation();
        test_game_over();
        test_priority();
        test_mid_game_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
